// File: rtl/i2c_target_regfile.sv
// I2C target exposing NREGS registers of REG_BYTES bytes, with atomic multi-byte commit and read snapshot.
// Optional 3-sample majority filter on SCL/SDA: define I2C_GLITCH_FILTER_EN.
module i2c_target_regfile #(
  parameter int unsigned NREGS = 5,
  parameter int unsigned REG_BYTES = 3,
  parameter logic [NREGS-1:0] RO_MASK = 5'b00110,
  parameter logic [NREGS*8*REG_BYTES-1:0] RESET_VAL = '0,
  localparam int unsigned PW = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int unsigned RW = 8 * REG_BYTES
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_scl,
  input  logic                I_sda,
  output logic                O_sda,
  output logic                OE_sda,
  input  logic [6:0]          I_myaddr,
  input  logic [NREGS*RW-1:0] I_regs,
  output logic [NREGS*RW-1:0] O_regs,
  output logic                O_wr_stb,
  output logic [PW-1:0]       O_wr_idx,
  output logic                O_busy
);

  localparam int unsigned BW = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c, scl_prev_q, sda_prev_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], I_scl};
      sda_sync_q <= {sda_sync_q[0], I_sda};
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_c & ~scl_prev_q;
  assign scl_fall = ~scl_c & scl_prev_q;
  assign start_ev = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_ev  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          rw_q, rw_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [7:0]    shadow_q [REG_BYTES];
  logic [7:0]    shadow_d [REG_BYTES];
  logic [7:0]    snap_q [REG_BYTES];
  logic [7:0]    snap_d [REG_BYTES];
  logic [RW-1:0] regs_q [NREGS];
  logic [RW-1:0] regs_d [NREGS];
  logic          oe_q, oe_d, busy_q, busy_d, stb_q, stb_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          load_first, take_snap, byte_done, bidx_last;

  logic [RW-1:0] ireg_w [NREGS];
  logic [RW-1:0] rst_w [NREGS];
  logic [PW-1:0] src_ptr;
  logic [RW-1:0] src_word, shadow_word;
  logic [7:0]    src_bytes [REG_BYTES];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign ireg_w[i] = I_regs[i*RW +: RW];
    assign rst_w[i]  = RESET_VAL[i*RW +: RW];
    assign O_regs[i*RW +: RW] = RO_MASK[i] ? '0 : regs_q[i];
  end

  for (genvar b = 0; b < REG_BYTES; b++) begin : g_byte
    assign src_bytes[b] = src_word[RW-1-8*b -: 8];
    assign shadow_word[RW-1-8*b -: 8] = shadow_q[b];
  end

  assign ptr_inc   = (ptr_q == PW'(NREGS - 1)) ? '0 : ptr_q + 1'b1;
  assign byte_done = (bit_cnt_q == 4'd8);
  assign bidx_last = (bidx_q == BW'(REG_BYTES - 1));
  // A snapshot taken while leaving RDATA_ACK belongs to the register after the pointer advance.
  assign src_ptr   = (state_q == StRdataAck) ? ptr_inc : ptr_q;
  assign src_word  = RO_MASK[src_ptr] ? ireg_w[src_ptr] : regs_q[src_ptr];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    bidx_d     = bidx_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    regs_d     = regs_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    stb_d      = 1'b0;
    idx_d      = idx_q;
    load_first = 1'b0;
    take_snap  = 1'b0;
    if (start_ev) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      bidx_d    = '0;
      oe_d      = 1'b0;
    end else if (stop_ev) begin
      state_d = StIdle;
      bidx_d  = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      sr_d      = {sr_q[6:0], sda_c};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else if (scl_fall) begin
      unique case (state_q)
        StAddr: if (byte_done) begin
          bit_cnt_d = '0;
          if (sr_q[7:1] == I_myaddr) begin
            state_d = StAddrAck;
            rw_d    = sr_q[0];
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
        StAddrAck: begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d    = StRdata;
            load_first = 1'b1;
            take_snap  = 1'b1;
          end else begin
            state_d = StPtr;
            oe_d    = 1'b0;
          end
        end
        StPtr: if (byte_done) begin
          bit_cnt_d = '0;
          if (32'(sr_q) < NREGS) begin
            state_d = StPtrAck;
            ptr_d   = sr_q[PW-1:0];
            bidx_d  = '0;
            oe_d    = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
        StPtrAck: begin
          state_d   = StWdata;
          bit_cnt_d = '0;
          oe_d      = 1'b0;
        end
        StWdata: if (byte_done) begin
          bit_cnt_d        = '0;
          shadow_d[bidx_q] = sr_q;
          if (RO_MASK[ptr_q]) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StWdataAck;
            oe_d    = 1'b1;
          end
        end
        StWdataAck: begin
          state_d   = StWdata;
          bit_cnt_d = '0;
          oe_d      = 1'b0;
          if (bidx_last) begin
            regs_d[ptr_q] = shadow_word;
            stb_d         = 1'b1;
            idx_d         = ptr_q;
            ptr_d         = ptr_inc;
            bidx_d        = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
        StRdata: begin
          if (byte_done) begin
            state_d   = StRdataAck;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
          end else begin
            oe_d = ~snap_q[bidx_q][~bit_cnt_q[2:0]];
          end
        end
        StRdataAck: begin
          bit_cnt_d = '0;
          if (bidx_last) begin
            bidx_d = '0;
            ptr_d  = ptr_inc;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
          if (!sr_q[0]) begin
            state_d    = StRdata;
            load_first = 1'b1;
            take_snap  = bidx_last;
          end else begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
      if (load_first) begin
        if (take_snap) snap_d = src_bytes;
        oe_d = ~snap_d[bidx_d][7];
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      bidx_q    <= '0;
      shadow_q  <= '{default: '0};
      snap_q    <= '{default: '0};
      regs_q    <= rst_w;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      bidx_q    <= bidx_d;
      shadow_q  <= shadow_d;
      snap_q    <= snap_d;
      regs_q    <= regs_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      stb_q     <= stb_d;
      idx_q     <= idx_d;
    end
  end

  assign OE_sda   = oe_q;
  assign O_sda    = ~oe_q;
  assign O_wr_stb = stb_q;
  assign O_wr_idx = idx_q;
  assign O_busy   = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C host, queue scoreboards for read bytes and write strobes.
module tb_i2c_target_regfile;
  localparam int NREGS = 5;
  localparam int RW = 24;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic host_sda = 1'b1;
  logic sda_bus;
  logic o_sda, oe_sda, wr_stb, busy;
  logic [2:0] wr_idx;
  logic [NREGS*RW-1:0] i_regs, o_regs;
  logic [23:0] ireg [NREGS];
  logic [23:0] oreg [NREGS];
  logic [23:0] mdl [NREGS];

  typedef struct {
    int          idx;
    logic [23:0] data;
  } stb_t;
  typedef struct {
    logic [7:0]  ptr;
    logic [23:0] data;
    bit          ro;
  } vec_t;

  stb_t       stb_q[$];
  logic [7:0] rd_q[$];
  int checks = 0;
  int errors = 0;
  bit oe_seen = 0;

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign i_regs[i*RW +: RW] = ireg[i];
    assign oreg[i] = o_regs[i*RW +: RW];
  end

  assign sda_bus = host_sda & ~(oe_sda & ~o_sda);

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .I_clk    (clk),
    .I_rst    (rst),
    .I_scl    (scl),
    .I_sda    (sda_bus),
    .O_sda    (o_sda),
    .OE_sda   (oe_sda),
    .I_myaddr (7'h2A),
    .I_regs   (i_regs),
    .O_regs   (o_regs),
    .O_wr_stb (wr_stb),
    .O_wr_idx (wr_idx),
    .O_busy   (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (oe_sda) oe_seen = 1'b1;
    if (!rst && wr_stb) begin
      stb_t e;
      chk("stb_pending", 32'(stb_q.size() != 0), 32'd1);
      if (stb_q.size() != 0) begin
        e = stb_q.pop_front();
        chk("stb_idx", 32'(wr_idx), 32'(e.idx));
        chk("stb_data", 32'(oreg[e.idx]), 32'(e.data));
      end
    end
  end

  task automatic i2c_start;
    host_sda = 1'b1; scl = 1'b1; w(Q);
    host_sda = 1'b0; w(Q);
    scl = 1'b0; w(Q);
  endtask

  task automatic i2c_rstart;
    host_sda = 1'b1; w(Q);
    scl = 1'b1; w(Q);
    host_sda = 1'b0; w(Q);
    scl = 1'b0; w(Q);
  endtask

  task automatic i2c_stop;
    host_sda = 1'b0; w(Q);
    scl = 1'b1; w(Q);
    host_sda = 1'b1; w(Q);
  endtask

  task automatic wb(input logic [7:0] d, input bit glitch, output bit ack);
    logic [7:0] s;
    s = d;
    for (int i = 0; i < 8; i++) begin
      host_sda = s[7];
      s = {s[6:0], 1'b0};
      w(Q);
      scl = 1'b1;
      if (glitch && i == 3) begin
        w(3); scl = 1'b0; w(1); scl = 1'b1; w(Q - 4);
      end else begin
        w(Q);
      end
      scl = 1'b0;
    end
    host_sda = 1'b1; w(Q);
    scl = 1'b1; w(Q / 2);
    ack = ~sda_bus;
    w(Q / 2);
    scl = 1'b0; w(Q);
  endtask

  task automatic wb_chk(input logic [7:0] d, input bit exp_ack, input string name);
    bit ack;
    wb(d, 1'b0, ack);
    chk(name, 32'(ack), 32'(exp_ack));
  endtask

  task automatic rd_chk(input bit nack, input string name);
    logic [7:0] b;
    b = '0;
    host_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w(Q); scl = 1'b1; w(Q / 2);
      b = {b[6:0], sda_bus};
      w(Q / 2); scl = 1'b0;
    end
    host_sda = nack; w(Q);
    scl = 1'b1; w(Q);
    scl = 1'b0; w(Q);
    host_sda = 1'b1;
    chk({name, "_sb"}, 32'(rd_q.size() != 0), 32'd1);
    if (rd_q.size() != 0) chk(name, 32'(b), 32'(rd_q.pop_front()));
  endtask

  task automatic push_reg(input logic [23:0] v);
    rd_q.push_back(v[23:16]);
    rd_q.push_back(v[15:8]);
    rd_q.push_back(v[7:0]);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    logic [23:0] e;
    bit ack;
    vecs[0] = '{ptr: 8'h03, data: 24'hA1B2C3, ro: 1'b0};
    vecs[1] = '{ptr: 8'h04, data: 24'hD4E5F6, ro: 1'b0};
    vecs[2] = '{ptr: 8'h00, data: 24'h0F1E2D, ro: 1'b0};
    vecs[3] = '{ptr: 8'h01, data: 24'h777777, ro: 1'b1};
    for (int i = 0; i < NREGS; i++) begin
      ireg[i] = 24'h0;
      mdl[i] = 24'h0;
    end
    ireg[1] = 24'h1A2B3C;
    ireg[2] = 24'hABCDEF;

    w(5);
    chk("rst_oe", 32'(oe_sda), 32'd0);
    chk("rst_osda", 32'(o_sda), 32'd1);
    chk("rst_stb", 32'(wr_stb), 32'd0);
    chk("rst_idx", 32'(wr_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg0", 32'(oreg[0]), 32'd0);
    rst = 1'b0;
    w(Q);

    // Basic write of reg0.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t1_addr_ack");
    chk("t1_busy", 32'(busy), 32'd1);
    wb_chk(8'h00, 1'b1, "t1_ptr_ack");
    wb_chk(8'h12, 1'b1, "t1_d0_ack");
    wb_chk(8'h34, 1'b1, "t1_d1_ack");
    stb_q.push_back('{idx: 0, data: 24'h123456});
    wb_chk(8'h56, 1'b1, "t1_d2_ack");
    i2c_stop;
    mdl[0] = 24'h123456;
    chk("t1_reg0", 32'(oreg[0]), 32'h123456);
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_ro_out_zero", 32'(oreg[1]), 32'd0);
    // Pointer should now be 1 (RO, sourced from I_regs).
    i2c_start;
    wb_chk(8'h55, 1'b1, "t1_rd_addr_ack");
    rd_q.push_back(8'h1A);
    rd_chk(1'b1, "t1_ptr1_byte");
    i2c_stop;

    foreach (vecs[v]) begin
      i2c_start;
      wb_chk(8'h54, 1'b1, "tbl_addr_ack");
      wb_chk(vecs[v].ptr, 1'b1, "tbl_ptr_ack");
      if (!vecs[v].ro) begin
        wb_chk(vecs[v].data[23:16], 1'b1, "tbl_d0_ack");
        wb_chk(vecs[v].data[15:8], 1'b1, "tbl_d1_ack");
        stb_q.push_back('{idx: int'(vecs[v].ptr), data: vecs[v].data});
        wb_chk(vecs[v].data[7:0], 1'b1, "tbl_d2_ack");
        mdl[vecs[v].ptr] = vecs[v].data;
      end else begin
        wb_chk(vecs[v].data[23:16], 1'b0, "tbl_ro_nack");
        chk("tbl_ro_busy", 32'(busy), 32'd0);
      end
      i2c_stop;
      i2c_start;
      wb_chk(8'h54, 1'b1, "tbl_rb_addr_ack");
      wb_chk(vecs[v].ptr, 1'b1, "tbl_rb_ptr_ack");
      i2c_rstart;
      wb_chk(8'h55, 1'b1, "tbl_rb_raddr_ack");
      e = vecs[v].ro ? ireg[vecs[v].ptr] : mdl[vecs[v].ptr];
      push_reg(e);
      rd_chk(1'b0, "tbl_rb_b0");
      rd_chk(1'b0, "tbl_rb_b1");
      rd_chk(1'b1, "tbl_rb_b2");
      i2c_stop;
    end

    // Read across a register boundary.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t2_addr_ack");
    wb_chk(8'h03, 1'b1, "t2_ptr_ack");
    i2c_rstart;
    wb_chk(8'h55, 1'b1, "t2_raddr_ack");
    push_reg(mdl[3]);
    rd_q.push_back(mdl[4][23:16]);
    rd_chk(1'b0, "t2_r3_b0");
    rd_chk(1'b0, "t2_r3_b1");
    rd_chk(1'b0, "t2_r3_b2");
    rd_chk(1'b1, "t2_r4_b0");
    chk("t2_released", 32'(oe_sda), 32'd0);
    chk("t2_busy_nack", 32'(busy), 32'd0);
    i2c_stop;

    // Snapshot holds while the RO source changes mid-read.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t3_addr_ack");
    wb_chk(8'h02, 1'b1, "t3_ptr_ack");
    i2c_rstart;
    wb_chk(8'h55, 1'b1, "t3_raddr_ack");
    push_reg(24'hABCDEF);
    rd_chk(1'b0, "t3_b0");
    ireg[2] = 24'h000000;
    rd_chk(1'b0, "t3_b1");
    rd_chk(1'b1, "t3_b2");
    i2c_stop;

    // Six-byte write wraps the pointer from 4 to 0.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t4_addr_ack");
    wb_chk(8'h04, 1'b1, "t4_ptr_ack");
    wb_chk(8'h11, 1'b1, "t4_d0");
    wb_chk(8'h22, 1'b1, "t4_d1");
    stb_q.push_back('{idx: 4, data: 24'h112233});
    wb_chk(8'h33, 1'b1, "t4_d2");
    wb_chk(8'h44, 1'b1, "t4_d3");
    wb_chk(8'h55, 1'b1, "t4_d4");
    stb_q.push_back('{idx: 0, data: 24'h445566});
    wb_chk(8'h66, 1'b1, "t4_d5");
    i2c_stop;
    mdl[4] = 24'h112233;
    mdl[0] = 24'h445566;
    chk("t4_reg4", 32'(oreg[4]), 32'h112233);
    chk("t4_reg0", 32'(oreg[0]), 32'h445566);

    // Out-of-range pointer and foreign address.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t5_addr_ack");
    wb_chk(8'h07, 1'b0, "t5_ptr_nack");
    chk("t5_busy", 32'(busy), 32'd0);
    i2c_stop;
    oe_seen = 1'b0;
    i2c_start;
    wb_chk(8'h60, 1'b0, "t5_foreign_nack");
    chk("t5_foreign_oe", 32'(oe_seen), 32'd0);
    chk("t5_foreign_busy", 32'(busy), 32'd0);
    i2c_stop;

    // Reset while driving read bit 3 of 0x44.
    i2c_start;
    wb_chk(8'h54, 1'b1, "t6_addr_ack");
    wb_chk(8'h00, 1'b1, "t6_ptr_ack");
    i2c_rstart;
    wb_chk(8'h55, 1'b1, "t6_raddr_ack");
    for (int i = 0; i < 4; i++) begin
      w(Q); scl = 1'b1; w(Q); scl = 1'b0;
    end
    w(Q);
    chk("t6_driving_bit3", 32'(oe_sda), 32'd1);
    rst = 1'b1;
    w(1);
    chk("t6_rst_oe", 32'(oe_sda), 32'd0);
    chk("t6_rst_osda", 32'(o_sda), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_stb", 32'(wr_stb), 32'd0);
    chk("t6_rst_idx", 32'(wr_idx), 32'd0);
    chk("t6_rst_reg0", 32'(oreg[0]), 32'd0);
    chk("t6_rst_reg4", 32'(oreg[4]), 32'd0);
    host_sda = 1'b1;
    w(2);
    scl = 1'b1;
    w(4);
    rst = 1'b0;
    w(Q);
    for (int i = 0; i < NREGS; i++) mdl[i] = 24'h0;

`ifdef I2C_GLITCH_FILTER_EN
    i2c_start;
    wb_chk(8'h54, 1'b1, "t7_addr_ack");
    wb_chk(8'h00, 1'b1, "t7_ptr_ack");
    wb(8'h9A, 1'b1, ack);
    chk("t7_glitch_ack", 32'(ack), 32'd1);
    wb_chk(8'hBC, 1'b1, "t7_d1");
    stb_q.push_back('{idx: 0, data: 24'h9ABCDE});
    wb_chk(8'hDE, 1'b1, "t7_d2");
    i2c_stop;
    chk("t7_reg0", 32'(oreg[0]), 32'h9ABCDE);
`endif

    w(Q);
    chk("stb_all_seen", 32'(stb_q.size()), 32'd0);
    chk("rd_all_seen", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
